// File: rtl/rob_tag_ctrl.sv
// rtl/rob_tag_ctrl.sv - ROB tag allocator with in-flight count and branch checkpoint tracking
module rob_tag_ctrl #(
    parameter int ROB_DEPTH = 8,
    parameter int MAX_CKPT  = 4,
    localparam int ROB_W    = $clog2(ROB_DEPTH),
    localparam int CKPT_W   = $clog2(MAX_CKPT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              recover_i,
    input  logic [ROB_W-1:0]  recover_tag_i,
    input  logic              alloc_fire_i,
    input  logic              alloc_is_br_i,
    input  logic              commit_i,
    input  logic              resolve_i,
    input  logic [ROB_W-1:0]  resolve_tag_i,
    output logic              tag_ok_o,
    output logic [ROB_W-1:0]  rob_tag_o,
    output logic [ROB_W-1:0]  head_tag_o,
    output logic [ROB_W:0]    count_o,
    output logic [CKPT_W-1:0] ckpt_cnt_o
);

    logic [ROB_W-1:0]     head, tail, head_n, tail_n;
    logic [ROB_W:0]       count, count_n;
    logic [ROB_DEPTH-1:0] br_map, br_map_n;
    logic [ROB_W:0]       pop;
    logic [ROB_W-1:0]     rec_dist;
    logic [ROB_W-1:0]     res_dist;
    logic                 full;

    always_comb begin
        pop = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            pop = pop + (ROB_W+1)'(br_map[i]);
        end
    end

    assign ckpt_cnt_o = CKPT_W'(pop);
    assign full       = (count == (ROB_W+1)'(ROB_DEPTH));
    assign tag_ok_o   = !full && (!alloc_is_br_i || ckpt_cnt_o < CKPT_W'(MAX_CKPT))
                        && !flush_i && !recover_i;
    assign rob_tag_o  = tail;
    assign head_tag_o = head;
    assign count_o    = count;

    // Ages are measured as distance from head so comparisons survive the wrap.
    assign rec_dist = recover_tag_i - head;
    assign res_dist = resolve_tag_i - head;

    always_comb begin
        head_n   = head;
        tail_n   = tail;
        count_n  = count;
        br_map_n = br_map;
        if (flush_i) begin
            head_n   = '0;
            tail_n   = '0;
            count_n  = '0;
            br_map_n = '0;
        end else if (recover_i) begin
            tail_n  = recover_tag_i + 1'b1;
            count_n = {1'b0, rec_dist} + 1'b1 - (ROB_W+1)'(commit_i);
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (ROB_W'(ROB_W'(i) - head) >= rec_dist) begin
                    br_map_n[i] = 1'b0;
                end
            end
            if (resolve_i && res_dist < rec_dist) begin
                br_map_n[resolve_tag_i] = 1'b0;
            end
            if (commit_i) begin
                head_n         = head + 1'b1;
                br_map_n[head] = 1'b0;
            end
        end else begin
            if (alloc_fire_i) begin
                tail_n = tail + 1'b1;
                if (alloc_is_br_i) begin
                    br_map_n[tail] = 1'b1;
                end
            end
            if (commit_i) begin
                head_n         = head + 1'b1;
                br_map_n[head] = 1'b0;
            end
            if (resolve_i) begin
                br_map_n[resolve_tag_i] = 1'b0;
            end
            count_n = count + (ROB_W+1)'(alloc_fire_i) - (ROB_W+1)'(commit_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            br_map <= '0;
        end else begin
            head   <= head_n;
            tail   <= tail_n;
            count  <= count_n;
            br_map <= br_map_n;
        end
    end

`ifndef SYNTHESIS
    a_alloc_ok: assert property (@(posedge clk) disable iff (!rst_n)
        !(alloc_fire_i && !tag_ok_o));
    a_commit_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
        !(commit_i && !flush_i && count == '0));
    a_resolve_live: assert property (@(posedge clk) disable iff (!rst_n)
        !(resolve_i && !flush_i && !recover_i && !br_map[resolve_tag_i]));
    a_recover_range: assert property (@(posedge clk) disable iff (!rst_n)
        !(recover_i && !flush_i && {1'b0, rec_dist} >= count));
`endif

endmodule
